// File: rtl/amba_ahb_pkg.sv
// -----------------------------------------------------------------------------
// amba_ahb_pkg
// Shared AHB-Lite encodings and controller state type for ahb_lite_arb_ctrl
// and its round-robin arbiter.
//   HTRANS_*  : transfer type codes (IDLE, NONSEQ only are used)
//   HBURST_*  : burst codes (SINGLE only)
//   HRESP_*   : slave response codes
//   HSIZE_*   : transfer size codes
//   HPROT_DEFAULT : data access, privileged, non-bufferable, non-cacheable
//   ahb_state_e   : controller FSM states
// -----------------------------------------------------------------------------
package amba_ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  localparam logic       HRESP_OKAY  = 1'b0;
  localparam logic       HRESP_ERROR = 1'b1;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic [3:0] HPROT_DEFAULT = 4'b0011;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ADDR = 2'b01,
    DATA = 2'b10
  } ahb_state_e;

endpackage

// File: rtl/rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin arbiter. The pick is combinational; the last-grant
// pointer is registered and moves only when the pick is actually taken.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   req[1:0]   : request vector
//   en         : 1 = the current pick is consumed this cycle
//   idx        : index of the picked requester (0 when nothing requests)
// -----------------------------------------------------------------------------
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       en,
  output logic       idx
);

  // Requester granted most recently; reset to 1 so requester 0 wins the
  // first contention.
  logic last;

  always_comb begin
    idx = 1'b0;
    if (req == 2'b11) begin
      idx = ~last;
    end else if (req == 2'b10) begin
      idx = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= 1'b1;
    end else if (en && (|req)) begin
      last <= idx;
    end
  end

endmodule

// File: rtl/ahb_lite_arb_ctrl.sv
// -----------------------------------------------------------------------------
// ahb_lite_arb_ctrl
// Two-requester AHB-Lite master controller. Commands from two requesters are
// arbitrated round-robin and each is issued as one SINGLE transfer
// (address phase, then data phase). Transfers never overlap.
// Optional feature macro: AHB_ARB_TIMEOUT_EN -- when defined, a data phase
// stalled for TIMEOUT_CYC cycles completes with an error ack.
// Ports:
//   hclk, hresetn        : bus clock, asynchronous active-low reset
//   req/req_we/req_addr/req_wdata/req_size : per-requester command (slice i)
//   ack, err, rdata      : one-cycle completion pulse, error flag, read data
//   haddr, htrans, hwrite, hsize, hburst, hprot, hwdata : AHB master outputs
//   hrdata, hready, hresp: AHB slave responses
// -----------------------------------------------------------------------------
module ahb_lite_arb_ctrl
  import amba_ahb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                hclk,
  input  logic                hresetn,
  input  logic [1:0]          req,
  input  logic [1:0]          req_we,
  input  logic [2*ADDR_W-1:0] req_addr,
  input  logic [2*DATA_W-1:0] req_wdata,
  input  logic [5:0]          req_size,
  output logic [1:0]          ack,
  output logic [1:0]          err,
  output logic [DATA_W-1:0]   rdata,
  output logic [ADDR_W-1:0]   haddr,
  output logic [1:0]          htrans,
  output logic                hwrite,
  output logic [2:0]          hsize,
  output logic [2:0]          hburst,
  output logic [3:0]          hprot,
  output logic [DATA_W-1:0]   hwdata,
  input  logic [DATA_W-1:0]   hrdata,
  input  logic                hready,
  input  logic                hresp
);

  ahb_state_e state, state_nxt;
  logic       gidx;
  logic       arb_idx;
  logic       grant;
  logic       tmo;

  // A grant is blocked during the ack cycle so a requester still holding req
  // while it sees its ack is not served twice.
  assign grant = (state == IDLE) && (|req) && hready && (ack == 2'b00);

  rr_arb2 u_arb (
    .clk   (hclk),
    .rst_n (hresetn),
    .req   (req),
    .en    (grant),
    .idx   (arb_idx)
  );

`ifdef AHB_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] wait_cnt;

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      wait_cnt <= '0;
    end else if (state == ADDR) begin
      wait_cnt <= '0;
    end else if ((state == DATA) && !hready) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Fires on the TIMEOUT_CYC-th stalled data-phase cycle.
  assign tmo = (state == DATA) && !hready &&
               (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
  assign tmo = 1'b0;
`endif

  assign hburst = HBURST_SINGLE;
  assign hprot  = HPROT_DEFAULT;

  always_comb begin
    state_nxt = state;
    htrans    = HTRANS_IDLE;
    case (state)
      IDLE: begin
        if (grant) state_nxt = ADDR;
      end
      ADDR: begin
        htrans    = HTRANS_NONSEQ;
        state_nxt = DATA;
      end
      DATA: begin
        if (hready || tmo) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      gidx   <= 1'b0;
      haddr  <= '0;
      hwrite <= 1'b0;
      hsize  <= '0;
      hwdata <= '0;
      ack    <= '0;
      err    <= '0;
      rdata  <= '0;
    end else begin
      ack <= '0;
      err <= '0;
      if (grant) begin
        gidx   <= arb_idx;
        haddr  <= arb_idx ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
        hwdata <= arb_idx ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
        hsize  <= arb_idx ? req_size[5:3] : req_size[2:0];
        hwrite <= arb_idx ? req_we[1] : req_we[0];
      end
      if (state == DATA) begin
        if (hready) begin
          ack <= gidx ? 2'b10 : 2'b01;
          if (hresp == HRESP_ERROR) begin
            err <= gidx ? 2'b10 : 2'b01;
          end else if (!hwrite) begin
            rdata <= hrdata;
          end
        end else if (tmo) begin
          ack <= gidx ? 2'b10 : 2'b01;
          err <= gidx ? 2'b10 : 2'b01;
        end
      end
    end
  end

endmodule

// File: tb/tb_ahb_lite_arb_ctrl.sv
// -----------------------------------------------------------------------------
// tb_ahb_lite_arb_ctrl
// Directed bench for ahb_lite_arb_ctrl (default build, AHB_ARB_TIMEOUT_EN
// undefined). Stimulus pushes hand-computed completions into a queue; a
// monitor pops and compares on every ack pulse. A small scripted slave
// answers each transfer with a chosen number of wait states / ERROR.
// -----------------------------------------------------------------------------
module tb_ahb_lite_arb_ctrl;
  import amba_ahb_pkg::*;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic [1:0]  req, req_we;
  logic [63:0] req_addr, req_wdata;
  logic [5:0]  req_size;
  logic [1:0]  ack, err;
  logic [31:0] rdata, haddr, hwdata, hrdata;
  logic [1:0]  htrans;
  logic        hwrite, hready, hresp;
  logic [2:0]  hsize, hburst;
  logic [3:0]  hprot;

  ahb_lite_arb_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(16)) dut (
    .hclk(hclk), .hresetn(hresetn), .req(req), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .ack(ack), .err(err), .rdata(rdata), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot),
    .hwdata(hwdata), .hrdata(hrdata), .hready(hready), .hresp(hresp)
  );

  always #5 hclk = ~hclk;

  int cyc = 0;
  always @(posedge hclk) cyc++;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [1:0]  ack;
    logic [1:0]  err;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;
  exp_t exp_q[$];

  // slave script
  int          ws = 0;
  bit          err_resp = 0;
  bit          stuck = 0;
  logic [31:0] rd_val = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge hclk);
    #1;
  endtask

  task automatic push(input logic [1:0] a, input logic [1:0] e, input logic [31:0] rd, input int c);
    exp_t x;
    x.ack = a; x.err = e; x.rdata = rd; x.cyc = c;
    exp_q.push_back(x);
  endtask

  task automatic launch(input int i, input logic we, input logic [31:0] a,
                        input logic [31:0] d, input logic [2:0] sz);
    req_we[i]           = we;
    req_addr[i*32 +: 32]  = a;
    req_wdata[i*32 +: 32] = d;
    req_size[i*3 +: 3]    = sz;
    req[i]              = 1'b1;
  endtask

  task automatic wait_ack(input int i, input int max);
    bit got = 0;
    for (int k = 0; k < max && !got; k++) begin
      step();
      if (ack[i]) begin
        got = 1;
        req[i] = 1'b0;
      end
    end
    if (!got) begin
      vectors++;
      miscompares++;
      $display("FAIL ack_timeout: req%0d got no ack, required within %0d cycles", i, max);
      req[i] = 1'b0;
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_htrans"}, 32'(htrans), 32'(HTRANS_IDLE));
    chk({tag, "_haddr"},  haddr, 32'h0);
    chk({tag, "_hwrite"}, 32'(hwrite), 32'h0);
    chk({tag, "_hsize"},  32'(hsize), 32'h0);
    chk({tag, "_hwdata"}, hwdata, 32'h0);
    chk({tag, "_ack"},    32'(ack), 32'h0);
    chk({tag, "_err"},    32'(err), 32'h0);
    chk({tag, "_rdata"},  rdata, 32'h0);
    chk({tag, "_hburst"}, 32'(hburst), 32'h0);
    chk({tag, "_hprot"},  32'(hprot), 32'h3);
  endtask

  // Monitor: every ack pulse is matched against the head of the queue.
  always @(negedge hclk) begin
    if (hresetn === 1'b1 && ack != 2'b00) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_ack", 32'(ack), 32'h0);
      end else begin
        exp_t x;
        x = exp_q.pop_front();
        chk("ack",       32'(ack), 32'(x.ack));
        chk("err",       32'(err), 32'(x.err));
        chk("rdata",     rdata, x.rdata);
        chk("ack_cycle", 32'(cyc), 32'(x.cyc));
      end
    end
  end

  // Scripted slave: reacts to each address phase.
  initial begin
    hready = 1'b1;
    hresp  = 1'b0;
    hrdata = '0;
    forever begin
      @(negedge hclk);
      if (hresetn === 1'b1 && htrans == HTRANS_NONSEQ) begin
        step();
        if (stuck) begin
          hready = 1'b0;
          while (stuck) @(negedge hclk);
          hready = 1'b1;
        end else begin
          for (int w = 0; w < ws; w++) begin
            hready = 1'b0;
            hresp  = err_resp && (w == ws - 1);
            chk("data_htrans_wait", 32'(htrans), 32'(HTRANS_IDLE));
            step();
          end
          hready = 1'b1;
          hresp  = err_resp;
          hrdata = rd_val;
          chk("data_htrans_last", 32'(htrans), 32'(HTRANS_IDLE));
          step();
          hresp = 1'b0;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    hresetn = 1'b0;
    req = '0; req_we = '0; req_addr = '0; req_wdata = '0; req_size = '0;
    repeat (2) step();
    chk_reset("por");

    // Contention held from reset: 0,1,0,1 every 4 cycles.
    launch(0, 1'b1, 32'h20, 32'h0000_00AA, HSIZE_WORD);
    launch(1, 1'b0, 32'h24, 32'h0, HSIZE_WORD);
    rd_val = 32'h1234_5678;
    c = cyc;
    hresetn = 1'b1;
    push(2'b01, 2'b00, 32'h0,         c + 3);
    push(2'b10, 2'b00, 32'h1234_5678, c + 7);
    push(2'b01, 2'b00, 32'h1234_5678, c + 11);
    push(2'b10, 2'b00, 32'h1234_5678, c + 15);
    step();
    chk("rr_haddr0", haddr, 32'h20);
    chk("rr_htrans0", 32'(htrans), 32'(HTRANS_NONSEQ));
    repeat (4) step();
    chk("rr_haddr1", haddr, 32'h24);
    chk("rr_hwrite1", 32'(hwrite), 32'h0);
    while (cyc < c + 15) step();
    req = '0;
    step();

    // Single write, zero wait states.
    c = cyc;
    launch(0, 1'b1, 32'h10, 32'hA5A5_0001, HSIZE_WORD);
    push(2'b01, 2'b00, 32'h1234_5678, c + 3);
    step();
    chk("wr_htrans", 32'(htrans), 32'(HTRANS_NONSEQ));
    chk("wr_haddr", haddr, 32'h10);
    chk("wr_hwrite", 32'(hwrite), 32'h1);
    chk("wr_hsize", 32'(hsize), 32'(HSIZE_WORD));
    step();
    chk("wr_htrans_data", 32'(htrans), 32'(HTRANS_IDLE));
    chk("wr_hwdata", hwdata, 32'hA5A5_0001);
    wait_ack(0, 8);
    step();

    // Read-back with two wait states.
    ws = 2;
    rd_val = 32'hA5A5_0001;
    c = cyc;
    launch(1, 1'b0, 32'h10, 32'h0, HSIZE_WORD);
    push(2'b10, 2'b00, 32'hA5A5_0001, c + 5);
    wait_ack(1, 12);
    ws = 0;
    step();

    // Two-cycle ERROR response; rdata must keep the previous read value.
    ws = 1;
    err_resp = 1;
    rd_val = 32'hDEAD_BEEF;
    c = cyc;
    launch(0, 1'b0, 32'hFFFF_FFF0, 32'h0, HSIZE_WORD);
    push(2'b01, 2'b01, 32'hA5A5_0001, c + 4);
    wait_ack(0, 12);
    ws = 0;
    err_resp = 0;
    step();

    // Stalled data phase: no ack ever, then reset aborts it.
    stuck = 1;
    c = cyc;
    launch(1, 1'b1, 32'h30, 32'h5555_AAAA, HSIZE_HALF);
    repeat (2) step();
    chk("stall_hwdata", hwdata, 32'h5555_AAAA);
    chk("stall_htrans", 32'(htrans), 32'(HTRANS_IDLE));
    repeat (12) step();
    chk("stall_no_ack", 32'(ack), 32'h0);
    hresetn = 1'b0;
    #1;
    chk_reset("mid");
    step();
    stuck = 0;
    repeat (2) step();
    c = cyc;
    hresetn = 1'b1;
    push(2'b10, 2'b00, 32'h0, c + 3);
    step();
    chk("regrant_htrans", 32'(htrans), 32'(HTRANS_NONSEQ));
    chk("regrant_haddr", haddr, 32'h30);
    chk("regrant_hsize", 32'(hsize), 32'(HSIZE_HALF));
    wait_ack(1, 8);
    repeat (3) step();

    chk("pending_expectations", 32'(exp_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ahb_lite_arb_ctrl.md
Name: ahb_lite_arb_ctrl

Overview:
- Two-requester AHB-Lite master-side controller.
- Accepts simple single-transfer read/write commands from two internal requesters and arbitrates round-robin between them.
- Sequences each granted command as one AHB-Lite SINGLE transfer (address phase, then data phase) to the shared amba_ahb_slave through the ifa bus signals.
- Returns read data, completion and error status to the requester.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT_CYC, 16, data-phase wait-state limit (used only with the optional feature)

Ports:
- hclk  in  1  bus clock; all logic on rising edge
- hresetn  in  1  asynchronous active-low reset
- req  in  2  per-requester command request; held until ack
- req_we  in  2  1 = write, 0 = read
- req_addr  in  2*ADDR_W  per-requester byte address; requester i in slice i
- req_wdata  in  2*DATA_W  per-requester write data
- req_size  in  2*3  per-requester HSIZE encoding
- ack  out  2  one-cycle completion pulse, one-hot
- err  out  2  valid with ack; 1 = slave returned ERROR
- rdata  out  DATA_W  read data, valid with ack on a read
- haddr  out  ADDR_W  AHB address
- htrans  out  2  IDLE or NONSEQ only
- hwrite  out  1  AHB direction
- hsize  out  3  AHB size
- hburst  out  3  constant SINGLE (3'b000)
- hprot  out  4  constant 4'b0011
- hwdata  out  DATA_W  AHB write data
- hrdata  in  DATA_W  AHB read data
- hready  in  1  AHB transfer done / slave ready
- hresp  in  1  0 = OKAY, 1 = ERROR

Behaviour:
- Reset values:
  - State IDLE.
  - htrans=IDLE, haddr=0, hwrite=0, hsize=0, hwdata=0.
  - ack=0, err=0, rdata=0.
  - Round-robin pointer favours requester 0.
- FSM IDLE -> ADDR -> DATA -> IDLE. No overlap of consecutive transfers.
- IDLE:
  - If any req is set and hready=1, grant one requester.
  - Latch its we/addr/wdata/size into internal registers.
  - Go to ADDR.
- Arbitration:
  - Single requester wins.
  - On simultaneous req, the requester not granted last wins.
  - Pointer updates on grant.
- ADDR: drive htrans=NONSEQ with the latched haddr/hwrite/hsize for exactly one cycle, then go to DATA.
- DATA:
  - htrans=IDLE.
  - hwdata holds the latched wdata for the whole data phase.
  - Wait while hready=0.
  - On hready=1 with hresp=0: pulse ack[g]=1 and err[g]=0; on a read, rdata=hrdata captured that edge. Return to IDLE.
- ERROR response (two cycles):
  - First cycle (hresp=1, hready=0): keep htrans=IDLE.
  - Second cycle (hresp=1, hready=1): pulse ack[g]=1, err[g]=1, leave rdata unchanged, return to IDLE.
- Latency: grant to ack = 3 cycles with zero wait states, plus 1 per wait state.
- Requester contract:
  - Payload stable while req is high.
  - Deasserting req before ack is ignored: the transfer completes and ack still pulses.
  - A requester may re-request the cycle after ack.
- Back-to-back: earliest next grant is the IDLE cycle following ack.
- hresetn low in any state aborts immediately to reset values. No ack for an aborted transfer.

Optional Feature:
- Macro: AHB_ARB_TIMEOUT_EN.
- Defined:
  - A counter runs in DATA while hready=0.
  - On reaching TIMEOUT_CYC, pulse ack[g]=1 and err[g]=1, drive htrans=IDLE, return to IDLE.
  - Counter clears on entering DATA.
- Undefined: no counter; DATA waits indefinitely.

Decomposition:
- Package amba_ahb_pkg holds:
  - HTRANS_IDLE=2'b00, HTRANS_NONSEQ=2'b10
  - HBURST_SINGLE
  - HRESP_OKAY/HRESP_ERROR
  - HSIZE_BYTE/HALF/WORD
  - state enum {IDLE, ADDR, DATA}
- Sub-module rr_arb2 (combinational 2-way round-robin pick plus registered last-grant pointer).

Test Plan:
- Single write: req[0] only, addr 0x10, wdata 0xA5A5_0001, size WORD, hready=1 -> NONSEQ 0x10 one cycle, hwdata=0xA5A5_0001 next cycle, ack=2'b01 3 cycles after req, err=0.
- Read-back with wait states: req[1] read 0x10, slave inserts 2 wait states then returns 0xA5A5_0001 -> ack=2'b10 at cycle 5, rdata=0xA5A5_0001.
- Contention: req=2'b11 held from reset -> grants alternate 0,1,0,1. Four acks in order 01,10,01,10, each 3 cycles apart plus 1 idle cycle.
- ERROR: slave responds ERROR to addr 0xFFFF_FFF0 -> htrans=IDLE during both ERROR cycles, ack=2'b01 with err=2'b01, rdata unchanged.
- Reset mid-transfer: hresetn low during DATA with hready=0 -> all outputs at reset values immediately. After release, no ack; the still-held req is re-granted and completes.
- AHB_ARB_TIMEOUT_EN with TIMEOUT_CYC=4, hready stuck 0 -> ack with err after 4 DATA cycles, FSM back to IDLE. Without the macro -> no ack.
